// File: rtl/m6809_bus_pkg.sv
// Shared types and constants for the 6809-style bus fabric.
package m6809_bus_pkg;

    localparam int unsigned WaitWidth     = 4;
    localparam int unsigned MaxRegions    = 8;
    localparam int unsigned IdxWidth      = $clog2(MaxRegions);
    localparam logic [7:0]  UnmappedRdata = 8'hFF;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } bus_state_e;

endpackage

// File: rtl/m6809_addr_match.sv
// Combinational region decoder: mask/compare per region, lowest matching index wins.
module m6809_addr_match
    import m6809_bus_pkg::*;
#(
    parameter int unsigned                NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'h8000, 16'h0000},
    parameter logic [NUM_REGIONS*16-1:0] REGION_MASK = {16'h8000, 16'h8000}
) (
    input  logic [15:0]         addr,
    output logic                hit,
    output logic [IdxWidth-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk from the top down so the lowest matching index is the last write.
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*16 +: 16]) == REGION_BASE[i*16 +: 16]) begin
                hit = 1'b1;
                idx = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/m6809_bus_fabric.sv
// Single-master bus fabric: decodes CPU accesses to device regions with per-region wait states.
// Optional unmapped-access error reporting is enabled by defining M6809_BUS_ERR_EN.
module m6809_bus_fabric
    import m6809_bus_pkg::*;
#(
    parameter int unsigned                NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*16-1:0] REGION_BASE = {16'h8000, 16'h0000},
    parameter logic [NUM_REGIONS*16-1:0] REGION_MASK = {16'h8000, 16'h8000},
    parameter logic [NUM_REGIONS*4-1:0]  REGION_WAIT = {4'd0, 4'd0}
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic                     cpu_req,
    input  logic [15:0]              cpu_addr,
    input  logic                     cpu_rw_n,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    output logic                     cpu_ready,
    output logic [NUM_REGIONS-1:0]   dev_sel,
    output logic [15:0]              dev_addr,
    output logic                     dev_wr_n,
    output logic [7:0]               dev_wdata,
    input  logic [NUM_REGIONS*8-1:0] dev_rdata,
    output logic                     bus_err,
    output logic [15:0]              err_addr
);

    bus_state_e           state_q, state_d;
    logic [15:0]          addr_q, addr_d;
    logic                 rw_n_q, rw_n_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic                 hit_q, hit_d;
    logic [WaitWidth-1:0] cnt_q, cnt_d;
    logic [7:0]           rdata_q, rdata_d;

    logic                 match_hit;
    logic [IdxWidth-1:0]  match_idx;
    logic [WaitWidth-1:0] match_wait;
    logic [7:0]           sel_rdata;
    logic                 access_end;

    m6809_addr_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_addr_match (
        .addr (cpu_addr),
        .hit  (match_hit),
        .idx  (match_idx)
    );

    // Unmapped accesses complete with no wait states.
    always_comb begin
        match_wait = '0;
        sel_rdata  = UnmappedRdata;
        for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (match_hit && match_idx == IdxWidth'(i)) begin
                match_wait = REGION_WAIT[i*4 +: 4];
            end
            if (hit_q && idx_q == IdxWidth'(i)) begin
                sel_rdata = dev_rdata[i*8 +: 8];
            end
        end
    end

    assign access_end = (state_q == StAccess) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_n_d  = rw_n_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d = StAccess;
                    addr_d  = cpu_addr;
                    rw_n_d  = cpu_rw_n;
                    wdata_d = cpu_wdata;
                    idx_d   = match_idx;
                    hit_d   = match_hit;
                    cnt_d   = match_wait;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (rw_n_q) begin
                        rdata_d = sel_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rw_n_q  <= 1'b1;
            wdata_q <= '0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_n_q  <= rw_n_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        dev_sel = '0;
        if (state_q == StAccess && hit_q) begin
            for (int i = 0; i < int'(NUM_REGIONS); i++) begin
                dev_sel[i] = (idx_q == IdxWidth'(i));
            end
        end
    end

    // Unmapped writes never strobe dev_wr_n.
    assign dev_wr_n  = !((state_q == StAccess) && !rw_n_q && hit_q);
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign cpu_ready = (state_q == StDone);

`ifdef M6809_BUS_ERR_EN
    logic [15:0] err_addr_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            err_addr_q <= '0;
        end else if (access_end && !hit_q) begin
            err_addr_q <= addr_q;
        end
    end

    assign bus_err  = (state_q == StDone) && !hit_q;
    assign err_addr = err_addr_q;
`else
    logic unused_access_end;
    assign unused_access_end = access_end;
    assign bus_err  = 1'b0;
    assign err_addr = 16'h0000;
`endif

endmodule

// File: tb/tb_m6809_bus_fabric.sv
// Randomized bench for m6809_bus_fabric: four configurations checked against a behavioural model.
module tb_m6809_bus_fabric;

    localparam int NumInst = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_b;
    logic [NumInst-1:0] req;
    logic [15:0]        addr;
    logic               rw_n;
    logic [7:0]         wdata;
    logic [63:0]        dev_rdata;

    logic [7:0]  rdata_o  [NumInst];
    logic        ready_o  [NumInst];
    logic [7:0]  sel_o    [NumInst];
    logic [15:0] daddr_o  [NumInst];
    logic        wr_n_o   [NumInst];
    logic [7:0]  dwdata_o [NumInst];
    logic        berr_o   [NumInst];
    logic [15:0] eaddr_o  [NumInst];
    logic [1:0]  sel0, sel2, sel3;
    logic [2:0]  sel1;

    assign sel_o[0] = {6'b0, sel0};
    assign sel_o[1] = {5'b0, sel1};
    assign sel_o[2] = {6'b0, sel2};
    assign sel_o[3] = {6'b0, sel3};

    // Defaults: region 0 = 0000-7FFF, region 1 = 8000-FFFF, no waits.
    m6809_bus_fabric u_dut0 (
        .clk(clk), .reset_b(reset_b), .cpu_req(req[0]), .cpu_addr(addr), .cpu_rw_n(rw_n),
        .cpu_wdata(wdata), .cpu_rdata(rdata_o[0]), .cpu_ready(ready_o[0]), .dev_sel(sel0),
        .dev_addr(daddr_o[0]), .dev_wr_n(wr_n_o[0]), .dev_wdata(dwdata_o[0]),
        .dev_rdata(dev_rdata[15:0]), .bus_err(berr_o[0]), .err_addr(eaddr_o[0])
    );

    m6809_bus_fabric #(
        .NUM_REGIONS (3),
        .REGION_BASE ({16'hF000, 16'h0000, 16'h1000}),
        .REGION_MASK ({16'hF000, 16'hF000, 16'hF000}),
        .REGION_WAIT ({4'd1, 4'd0, 4'd3})
    ) u_dut1 (
        .clk(clk), .reset_b(reset_b), .cpu_req(req[1]), .cpu_addr(addr), .cpu_rw_n(rw_n),
        .cpu_wdata(wdata), .cpu_rdata(rdata_o[1]), .cpu_ready(ready_o[1]), .dev_sel(sel1),
        .dev_addr(daddr_o[1]), .dev_wr_n(wr_n_o[1]), .dev_wdata(dwdata_o[1]),
        .dev_rdata(dev_rdata[23:0]), .bus_err(berr_o[1]), .err_addr(eaddr_o[1])
    );

    m6809_bus_fabric #(
        .REGION_WAIT ({4'd3, 4'd0})
    ) u_dut2 (
        .clk(clk), .reset_b(reset_b), .cpu_req(req[2]), .cpu_addr(addr), .cpu_rw_n(rw_n),
        .cpu_wdata(wdata), .cpu_rdata(rdata_o[2]), .cpu_ready(ready_o[2]), .dev_sel(sel2),
        .dev_addr(daddr_o[2]), .dev_wr_n(wr_n_o[2]), .dev_wdata(dwdata_o[2]),
        .dev_rdata(dev_rdata[15:0]), .bus_err(berr_o[2]), .err_addr(eaddr_o[2])
    );

    // Overlap: region 0 (01xx) sits inside region 1 (0xxx).
    m6809_bus_fabric #(
        .REGION_BASE ({16'h0000, 16'h0100}),
        .REGION_MASK ({16'hF000, 16'hFF00}),
        .REGION_WAIT ({4'd2, 4'd1})
    ) u_dut3 (
        .clk(clk), .reset_b(reset_b), .cpu_req(req[3]), .cpu_addr(addr), .cpu_rw_n(rw_n),
        .cpu_wdata(wdata), .cpu_rdata(rdata_o[3]), .cpu_ready(ready_o[3]), .dev_sel(sel3),
        .dev_addr(daddr_o[3]), .dev_wr_n(wr_n_o[3]), .dev_wdata(dwdata_o[3]),
        .dev_rdata(dev_rdata[15:0]), .bus_err(berr_o[3]), .err_addr(eaddr_o[3])
    );

    // Reference configuration and model state
    logic [15:0] cfg_base [NumInst][8];
    logic [15:0] cfg_mask [NumInst][8];
    int          cfg_wait [NumInst][8];
    int          cfg_nreg [NumInst];
    logic [7:0]  last_rdata [NumInst];
    logic [15:0] last_err   [NumInst];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_region(input int k, input int r, input logic [15:0] b,
                              input logic [15:0] m, input int w);
        cfg_base[k][r] = b;
        cfg_mask[k][r] = m;
        cfg_wait[k][r] = w;
    endtask

    task automatic init_cfg();
        cfg_nreg[0] = 2; set_region(0, 0, 16'h0000, 16'h8000, 0);
        set_region(0, 1, 16'h8000, 16'h8000, 0);
        cfg_nreg[1] = 3; set_region(1, 0, 16'h1000, 16'hF000, 3);
        set_region(1, 1, 16'h0000, 16'hF000, 0); set_region(1, 2, 16'hF000, 16'hF000, 1);
        cfg_nreg[2] = 2; set_region(2, 0, 16'h0000, 16'h8000, 0);
        set_region(2, 1, 16'h8000, 16'h8000, 3);
        cfg_nreg[3] = 2; set_region(3, 0, 16'h0100, 16'hFF00, 1);
        set_region(3, 1, 16'h0000, 16'hF000, 2);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NumInst; k++) begin
            last_rdata[k] = 8'h00;
            last_err[k]   = 16'h0000;
        end
    endtask

    // First region (in index order) whose masked address equals its base; -1 if none.
    function automatic int exp_region(input int k, input logic [15:0] a);
        int r = -1;
        for (int i = 0; i < cfg_nreg[k]; i++)
            if (r < 0 && (a & cfg_mask[k][i]) == cfg_base[k][i]) r = i;
        return r;
    endfunction

    // Called at a falling edge while the target instance is idle.
    task automatic access(input int k, input logic [15:0] a, input logic rw, input logic [7:0] wd);
        int reg_i, wt, ready_at, sel_cycles, wr_cycles, bad_sel, bad_bus;
        logic [7:0] exp_sel;
        reg_i = exp_region(k, a);
        wt = (reg_i >= 0) ? cfg_wait[k][reg_i] : 0;
        exp_sel = (reg_i >= 0) ? 8'(1 << reg_i) : 8'h00;
        if (rw) last_rdata[k] = (reg_i >= 0) ? dev_rdata[reg_i*8 +: 8] : 8'hFF;
        if (reg_i < 0) last_err[k] = a;
        addr = a; rw_n = rw; wdata = wd; req[k] = 1'b1;
        @(posedge clk);
        #1;
        req[k] = 1'b0;
        // Scramble the request bus so only latched values can reach the device side.
        addr = 16'($urandom); rw_n = 1'($urandom); wdata = 8'($urandom);
        ready_at = 0; sel_cycles = 0; wr_cycles = 0; bad_sel = 0; bad_bus = 0;
        for (int c = 1; c <= 24 && ready_at == 0; c++) begin
            @(negedge clk);
            if (sel_o[k] != 8'h00) begin
                sel_cycles++;
                if (sel_o[k] != exp_sel) bad_sel++;
                if (daddr_o[k] != a || dwdata_o[k] != wd) bad_bus++;
            end
            if (!wr_n_o[k]) wr_cycles++;
            if (ready_o[k]) begin
                ready_at = c;
                check("rdata", 32'(rdata_o[k]), 32'(last_rdata[k]));
`ifdef M6809_BUS_ERR_EN
                check("bus_err", 32'(berr_o[k]), 32'(reg_i < 0));
                check("err_addr", 32'(eaddr_o[k]), 32'(last_err[k]));
`else
                check("bus_err", 32'(berr_o[k]), 32'd0);
                check("err_addr", 32'(eaddr_o[k]), 32'd0);
`endif
            end
        end
        check("ready_latency", 32'(ready_at), 32'(wt + 2));
        check("sel_cycles", 32'(sel_cycles), 32'((reg_i >= 0) ? wt + 1 : 0));
        check("sel_value", 32'(bad_sel), 32'd0);
        check("dev_bus", 32'(bad_bus), 32'd0);
        check("wr_cycles", 32'(wr_cycles), 32'((reg_i >= 0 && !rw) ? wt + 1 : 0));
        @(posedge clk);
        @(negedge clk);
        check("ready_drop", 32'(ready_o[k]), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NumInst; k++) begin
            check({tag, "_ready"}, 32'(ready_o[k]), 32'd0);
            check({tag, "_rdata"}, 32'(rdata_o[k]), 32'd0);
            check({tag, "_sel"}, 32'(sel_o[k]), 32'd0);
            check({tag, "_wr_n"}, 32'(wr_n_o[k]), 32'd1);
            check({tag, "_daddr"}, 32'(daddr_o[k]), 32'd0);
            check({tag, "_dwdata"}, 32'(dwdata_o[k]), 32'd0);
            check({tag, "_berr"}, 32'(berr_o[k]), 32'd0);
            check({tag, "_eaddr"}, 32'(eaddr_o[k]), 32'd0);
        end
    endtask

    initial begin
        int pos [3];
        int nready, late_ready, k;
        logic [15:0] a;

        init_cfg();
        model_reset();
        reset_b = 1'b0; req = '0; addr = '0; rw_n = 1'b1; wdata = '0; dev_rdata = '0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_b = 1'b1;
        @(negedge clk);

        // Default config read from region 1
        dev_rdata = {$urandom, $urandom};
        dev_rdata[15:8] = 8'hA5;
        access(0, 16'h8010, 1'b1, 8'h00);
        check("dflt_read_a5", 32'(rdata_o[0]), 32'h0000_00A5);

        // Three wait states on a write
        access(2, 16'h9000, 1'b0, 8'h5A);

        // Unmapped read in the three-region config
        access(1, 16'h2000, 1'b1, 8'h00);
        check("unmapped_ff", 32'(rdata_o[1]), 32'h0000_00FF);

        // Overlapping regions resolve to region 0
        dev_rdata[7:0] = 8'h3C;
        access(3, 16'h0100, 1'b1, 8'h00);
        check("overlap_rdata", 32'(rdata_o[3]), 32'h0000_003C);

        // Reset during the second ACCESS cycle of a 3-wait read
        dev_rdata[7:0] = 8'h77;
        access(2, 16'h1234, 1'b1, 8'h00);
        dev_rdata[15:8] = 8'hC3;
        addr = 16'h9000; rw_n = 1'b1; req[2] = 1'b1;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        @(posedge clk);
        #2;
        check("rst_pre_sel", 32'(sel_o[2]), 32'h2);
        reset_b = 1'b0;
        #1;
        model_reset();
        check_reset_state("mid_reset");
        @(negedge clk);
        reset_b = 1'b1;
        late_ready = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready_o[2]) late_ready++;
        end
        check("rst_no_ready", 32'(late_ready), 32'd0);
        check("rst_rdata", 32'(rdata_o[2]), 32'd0);

        // Back-to-back reads with cpu_req held high
        dev_rdata[15:8] = 8'h11;
        addr = 16'h8000; rw_n = 1'b1; req[0] = 1'b1;
        nready = 0;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ready_o[0]) begin
                if (nready < 3) pos[nready] = c;
                nready++;
            end
        end
        req[0] = 1'b0;
        late_ready = 0;
        repeat (4) begin
            @(negedge clk);
            if (ready_o[0]) late_ready++;
        end
        last_rdata[0] = 8'h11;
        check("b2b_count", 32'(nready), 32'd3);
        check("b2b_first", 32'(pos[0]), 32'd2);
        check("b2b_second", 32'(pos[1]), 32'd5);
        check("b2b_third", 32'(pos[2]), 32'd8);
        check("b2b_after", 32'(late_ready), 32'd0);
        check("b2b_rdata", 32'(rdata_o[0]), 32'h11);

        // Randomized traffic across all four configurations
        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, NumInst - 1));
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0: a[15:8]  = 8'h01;
                1: a[15:12] = 4'h0;
                2: a[15:12] = 4'hF;
                3: a[15:12] = 4'h1;
                default: ;
            endcase
            dev_rdata = {$urandom, $urandom};
            access(k, a, 1'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
